// File: rtl/stock_keeper_pkg.sv
// Shared definitions for the stock keeper: sizes, lane/count types and the
// inquiry FSM state encoding.
package stock_keeper_pkg;

  localparam int LANES   = 8;
  localparam int LANE_W  = 3;
  localparam int CNT_W   = 7;
  localparam int MAX_CNT = 99;

  // Lane index, shared with the admin block and the display.
  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam cnt_t  MAX_CNT_V = cnt_t'(MAX_CNT);
  localparam lane_t LAST_LANE = lane_t'(LANES - 1);

endpackage

// File: rtl/stock_sat_add.sv
// Combinational count arithmetic: saturating add of a replenish quantity, or
// a decrement that refuses to go below zero.
//   dec = 0 : result = min(cur + qty, MAX_CNT), sat = clamp happened
//   dec = 1 : result = cur - 1 (cur unchanged when 0), sat = cur was empty
module stock_sat_add
  import stock_keeper_pkg::*;
(
  input  logic [CNT_W-1:0] cur,
  input  logic [CNT_W-1:0] qty,
  input  logic             dec,
  output logic [CNT_W-1:0] result,
  output logic             sat
);

  // One bit wider so the overflow above MAX_CNT is visible before clamping.
  logic [CNT_W:0] sum;

  // Select between add-with-clamp and guarded decrement.
  always_comb begin
    // NOTE: every output gets a default before the branches so no path leaves a latch.
    sum    = {1'b0, cur} + {1'b0, qty};
    result = cur;
    sat    = 1'b0;
    if (dec) begin
      if (cur == '0) begin
        sat = 1'b1;
      end else begin
        result = cur - cnt_t'(1);
      end
    end else if (sum > {1'b0, MAX_CNT_V}) begin
      result = MAX_CNT_V;
      sat    = 1'b1;
    end else begin
      result = sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/stock_keeper.sv
// Per-lane goods counts for the vending machine. Executes admin clear,
// replenish and inquiry commands (inquiry streams one lane per cycle) and
// serves customer sale decrements from the purchase path.
module stock_keeper
  import stock_keeper_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              rep_valid,
  input  logic [LANE_W-1:0] rep_lane,
  input  logic [CNT_W-1:0]  rep_qty,
  output logic              rep_ack,
  output logic              rep_sat,
  input  logic              inq_req,
  output logic              inq_busy,
  output logic              inq_valid,
  output logic [LANE_W-1:0] inq_lane,
  output logic [CNT_W-1:0]  inq_count,
  output logic              inq_done,
  input  logic              sale_valid,
  input  logic [LANE_W-1:0] sale_lane,
  output logic              sale_ok,
  output logic              sale_fail,
  output logic [LANES-1:0]  empty_mask
);

  state_t state;
  cnt_t   count      [LANES];
  cnt_t   next_count [LANES];

  logic  idle;
  logic  clr_go;
  logic  rep_go;
  logic  sale_go;
  cnt_t  add_result;
  logic  add_sat;
  cnt_t  dec_result;
  logic  dec_empty;
  lane_t scan_next;

  assign idle      = (state == IDLE);
  assign scan_next = inq_lane + lane_t'(1);

  stock_sat_add u_add (
    .cur    (count[rep_lane]),
    .qty    (rep_qty),
    .dec    (1'b0),
    .result (add_result),
    .sat    (add_sat)
  );

  stock_sat_add u_dec (
    .cur    (count[sale_lane]),
    .qty    ('0),
    .dec    (1'b1),
    .result (dec_result),
    .sat    (dec_empty)
  );

  // Arbitrate clr > rep > sale and form the counts for the next cycle.
  always_comb begin
    clr_go = en & clr & idle;
    // A held request is not re-applied in the cycle its ack is showing.
    rep_go = en & rep_valid & ~rep_ack & idle & ~clr_go;
    sale_go = sale_valid & ~dec_empty & ~clr_go
            & ~(rep_go & (rep_lane == sale_lane));
    for (int i = 0; i < LANES; i++) begin
      next_count[i] = clr_go ? '0 : count[i];
    end
    if (rep_go) begin
      next_count[rep_lane] = add_result;
    end
    if (sale_go) begin
      next_count[sale_lane] = dec_result;
    end
  end

  // Count registers, command responses and the empty map.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the count array is reset explicitly; it is a small register file and must come up as all-empty.
      for (int i = 0; i < LANES; i++) begin
        count[i] <= '0;
      end
      rep_ack    <= 1'b0;
      rep_sat    <= 1'b0;
      sale_ok    <= 1'b0;
      sale_fail  <= 1'b0;
      empty_mask <= '1;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        count[i]      <= next_count[i];
        empty_mask[i] <= (next_count[i] == '0);
      end
      rep_ack   <= rep_go;
      rep_sat   <= rep_go & add_sat;
      sale_ok   <= sale_go;
      sale_fail <= sale_valid & ~sale_go;
    end
  end

  // Inquiry FSM: walk lanes 0..LANES-1, then one DONE pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: registers use non-blocking assignments so every update sees the same pre-edge values.
      state     <= IDLE;
      inq_busy  <= 1'b0;
      inq_valid <= 1'b0;
      inq_lane  <= '0;
      inq_count <= '0;
      inq_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en && inq_req) begin
            state     <= SCAN;
            inq_busy  <= 1'b1;
            inq_valid <= 1'b1;
            inq_lane  <= '0;
            inq_count <= next_count[0];
          end
        end
        SCAN: begin
          if (inq_lane == LAST_LANE) begin
            state     <= DONE;
            inq_valid <= 1'b0;
            inq_done  <= 1'b1;
          end else begin
            // Report the value the lane holds in the cycle it is shown.
            inq_lane  <= scan_next;
            inq_count <= next_count[scan_next];
          end
        end
        DONE: begin
          state    <= IDLE;
          inq_done <= 1'b0;
          inq_busy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stock_keeper.sv
// Bench for stock_keeper: directed scenario tasks plus a randomized run, all
// tracked by a lane-count reference model that predicts every output cycle.
module tb_stock_keeper;
  import stock_keeper_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       clr = 1'b0;
  logic       rep_valid = 1'b0;
  logic [2:0] rep_lane = 3'd0;
  logic [6:0] rep_qty = 7'd0;
  logic       inq_req = 1'b0;
  logic       sale_valid = 1'b0;
  logic [2:0] sale_lane = 3'd0;
  logic       rep_ack, rep_sat, inq_busy, inq_valid, inq_done, sale_ok, sale_fail;
  logic [2:0] inq_lane;
  logic [6:0] inq_count;
  logic [7:0] empty_mask;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  stock_keeper dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
    .rep_valid(rep_valid), .rep_lane(rep_lane), .rep_qty(rep_qty),
    .rep_ack(rep_ack), .rep_sat(rep_sat),
    .inq_req(inq_req), .inq_busy(inq_busy), .inq_valid(inq_valid),
    .inq_lane(inq_lane), .inq_count(inq_count), .inq_done(inq_done),
    .sale_valid(sale_valid), .sale_lane(sale_lane),
    .sale_ok(sale_ok), .sale_fail(sale_fail), .empty_mask(empty_mask)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Goods per lane as plain integers; scan position -1 = idle, 0..7 = lane
  // being reported, 8 = done pulse.
  int         m_cnt [8];
  int         m_pos = -1;
  int         m_sum;
  bit         m_idle, m_clr, m_rep, m_sale;
  logic       e_rep_ack = 0, e_rep_sat = 0, e_sale_ok = 0, e_sale_fail = 0;
  logic       e_busy = 0, e_inq_valid = 0, e_inq_done = 0;
  logic [2:0] e_inq_lane = 0;
  logic [6:0] e_inq_count = 0;
  logic [7:0] e_empty = 8'hFF;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      m_pos = -1;
      {e_rep_ack, e_rep_sat, e_sale_ok, e_sale_fail, e_busy, e_inq_valid, e_inq_done} = '0;
      e_inq_lane = 0;
      e_inq_count = 0;
    end else begin
      m_idle = (m_pos < 0);
      m_clr  = en && clr && m_idle;
      m_rep  = en && rep_valid && m_idle && !m_clr && !e_rep_ack;
      m_sale = sale_valid && !m_clr && !(m_rep && rep_lane == sale_lane)
               && m_cnt[sale_lane] > 0;
      e_rep_ack   = m_rep;
      e_rep_sat   = 1'b0;
      e_sale_ok   = m_sale;
      e_sale_fail = sale_valid && !m_sale;
      if (m_clr) for (int i = 0; i < 8; i++) m_cnt[i] = 0;
      if (m_rep) begin
        m_sum = m_cnt[rep_lane] + int'(rep_qty);
        e_rep_sat = (m_sum > 99);
        m_cnt[rep_lane] = (m_sum > 99) ? 99 : m_sum;
      end
      if (m_sale) m_cnt[sale_lane] = m_cnt[sale_lane] - 1;
      if (m_pos < 0) begin
        if (en && inq_req) m_pos = 0;
      end else if (m_pos < 8) m_pos = m_pos + 1;
      else m_pos = -1;
      e_inq_valid = (m_pos >= 0 && m_pos < 8);
      e_inq_done  = (m_pos == 8);
      e_busy      = (m_pos >= 0);
      if (e_inq_valid) begin
        e_inq_lane  = 3'(m_pos);
        e_inq_count = 7'(m_cnt[m_pos]);
      end
    end
    for (int i = 0; i < 8; i++) e_empty[i] = (m_cnt[i] == 0);
  end

  logic [24:0] obs_v, exp_v;
  assign obs_v = {rep_ack, rep_sat, sale_ok, sale_fail, inq_busy, inq_valid, inq_done, empty_mask,
                  (inq_valid ? inq_lane : 3'd0), (inq_valid ? inq_count : 7'd0)};
  assign exp_v = {e_rep_ack, e_rep_sat, e_sale_ok, e_sale_fail, e_busy, e_inq_valid, e_inq_done, e_empty,
                  (e_inq_valid ? e_inq_lane : 3'd0), (e_inq_valid ? e_inq_count : 7'd0)};

  // Lockstep comparison against the model every cycle once out of reset.
  always @(negedge clk) begin
    if (mon_on) begin
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL lockstep t=%0t got %h expected %h", $time, obs_v, exp_v);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold a replenish request until acked; returns cycles to ack (-1 on timeout).
  task automatic do_rep(input int lane, input int qty, output int lat, output logic sat);
    rep_lane  = 3'(lane);
    rep_qty   = 7'(qty);
    rep_valid = 1'b1;
    lat = -1;
    sat = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (rep_ack) begin
        lat = c;
        sat = rep_sat;
        break;
      end
    end
    rep_valid = 1'b0;
    tick();
  endtask

  int scan_cnt [8];
  int scan_seen;
  bit scan_done;

  // Run one inquiry and record what the DUT reported; ends back in IDLE.
  task automatic run_scan();
    scan_seen = 0;
    scan_done = 1'b0;
    for (int i = 0; i < 8; i++) scan_cnt[i] = -1;
    inq_req = 1'b1;
    tick();
    inq_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (inq_valid) begin
        scan_cnt[inq_lane] = int'(inq_count);
        scan_seen++;
      end
      if (inq_done) begin
        scan_done = 1'b1;
        break;
      end
      tick();
    end
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({rep_ack, rep_sat, sale_ok, sale_fail} !== 4'b0) begin
      errors++;
      $display("FAIL reset_pulses got %b expected 0000", {rep_ack, rep_sat, sale_ok, sale_fail});
    end
    checks++;
    if ({inq_busy, inq_valid, inq_done} !== 3'b0 || inq_lane !== 3'd0 || inq_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_inq got busy/valid/done %b lane %0d count %0d expected all 0",
               {inq_busy, inq_valid, inq_done}, inq_lane, inq_count);
    end
    checks++;
    if (empty_mask !== 8'hFF) begin
      errors++;
      $display("FAIL reset_empty got %h expected ff", empty_mask);
    end
    rst = 1'b0;
    mon_on = 1'b1;
  endtask

  task automatic test_scan_empty();
    en = 1'b1;
    inq_req = 1'b1;
    tick();
    inq_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (inq_valid !== 1'b1 || inq_lane !== 3'(k) || inq_count !== 7'd0) begin
        errors++;
        $display("FAIL scan_empty step %0d got valid %b lane %0d count %0d expected 1 %0d 0",
                 k, inq_valid, inq_lane, inq_count, k);
      end
      tick();
    end
    checks++;
    if (inq_done !== 1'b1 || inq_valid !== 1'b0) begin
      errors++;
      $display("FAIL scan_done got done %b valid %b expected 1 0", inq_done, inq_valid);
    end
    tick();
    checks++;
    if (inq_done !== 1'b0 || inq_busy !== 1'b0 || empty_mask !== 8'hFF) begin
      errors++;
      $display("FAIL scan_end got done %b busy %b empty %h expected 0 0 ff", inq_done, inq_busy, empty_mask);
    end
  endtask

  task automatic test_replenish();
    int lat;
    logic sat;
    do_rep(3, 40, lat, sat);
    checks++;
    if (lat != 1 || sat !== 1'b0) begin
      errors++;
      $display("FAIL rep_40 got latency %0d sat %b expected 1 0", lat, sat);
    end
    run_scan();
    checks++;
    if (scan_cnt[3] != 40 || scan_seen != 8 || !scan_done) begin
      errors++;
      $display("FAIL rep_40_count got %0d (lanes %0d done %b) expected 40", scan_cnt[3], scan_seen, scan_done);
    end
    do_rep(3, 70, lat, sat);
    checks++;
    if (lat != 1 || sat !== 1'b1) begin
      errors++;
      $display("FAIL rep_sat got latency %0d sat %b expected 1 1", lat, sat);
    end
    checks++;
    if (empty_mask[3] !== 1'b0) begin
      errors++;
      $display("FAIL rep_empty3 got %b expected 0", empty_mask[3]);
    end
    do_rep(3, 0, lat, sat);
    checks++;
    if (lat != 1 || sat !== 1'b0) begin
      errors++;
      $display("FAIL rep_zero got latency %0d sat %b expected 1 0", lat, sat);
    end
    run_scan();
    checks++;
    if (scan_cnt[3] != 99) begin
      errors++;
      $display("FAIL rep_99_count got %0d expected 99", scan_cnt[3]);
    end
  endtask

  task automatic test_gating();
    en = 1'b0;
    rep_lane = 3'd2;
    rep_qty = 7'd5;
    rep_valid = 1'b1;
    clr = 1'b1;
    inq_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (rep_ack !== 1'b0 || inq_busy !== 1'b0 || empty_mask[2] !== 1'b1 || empty_mask[3] !== 1'b0) begin
        errors++;
        $display("FAIL gated cycle %0d got ack %b busy %b empty %h expected 0 0 with bit2=1 bit3=0",
                 c, rep_ack, inq_busy, empty_mask);
      end
    end
    clr = 1'b0;
    inq_req = 1'b0;
    en = 1'b1;
    tick();
    checks++;
    if (rep_ack !== 1'b1 || empty_mask[2] !== 1'b0) begin
      errors++;
      $display("FAIL ungated got ack %b empty2 %b expected 1 0", rep_ack, empty_mask[2]);
    end
    rep_valid = 1'b0;
    tick();
    run_scan();
    checks++;
    if (scan_cnt[2] != 5) begin
      errors++;
      $display("FAIL ungated_count got %0d expected 5", scan_cnt[2]);
    end
  endtask

  task automatic test_sale();
    int lat;
    logic sat;
    do_rep(5, 1, lat, sat);
    sale_lane = 3'd5;
    sale_valid = 1'b1;
    tick();
    checks++;
    if (sale_ok !== 1'b1 || sale_fail !== 1'b0) begin
      errors++;
      $display("FAIL sale_first got ok %b fail %b expected 1 0", sale_ok, sale_fail);
    end
    tick();
    sale_valid = 1'b0;
    checks++;
    if (sale_ok !== 1'b0 || sale_fail !== 1'b1 || empty_mask[5] !== 1'b1) begin
      errors++;
      $display("FAIL sale_empty got ok %b fail %b empty5 %b expected 0 1 1", sale_ok, sale_fail, empty_mask[5]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    logic sat;
    do_rep(4, 10, lat, sat);
    do_rep(6, 3, lat, sat);
    rep_lane = 3'd4;
    rep_qty = 7'd2;
    rep_valid = 1'b1;
    sale_lane = 3'd4;
    sale_valid = 1'b1;
    tick();
    rep_valid = 1'b0;
    sale_valid = 1'b0;
    checks++;
    if (rep_ack !== 1'b1 || sale_fail !== 1'b1 || sale_ok !== 1'b0) begin
      errors++;
      $display("FAIL same_lane got ack %b fail %b ok %b expected 1 1 0", rep_ack, sale_fail, sale_ok);
    end
    tick();
    run_scan();
    checks++;
    if (scan_cnt[4] != 12) begin
      errors++;
      $display("FAIL same_lane_count got %0d expected 12", scan_cnt[4]);
    end
    rep_valid = 1'b1;
    sale_lane = 3'd6;
    sale_valid = 1'b1;
    tick();
    rep_valid = 1'b0;
    sale_valid = 1'b0;
    checks++;
    if (rep_ack !== 1'b1 || sale_ok !== 1'b1 || sale_fail !== 1'b0) begin
      errors++;
      $display("FAIL diff_lane got ack %b ok %b fail %b expected 1 1 0", rep_ack, sale_ok, sale_fail);
    end
    tick();
    run_scan();
    checks++;
    if (scan_cnt[4] != 14 || scan_cnt[6] != 2) begin
      errors++;
      $display("FAIL diff_lane_count got lane4 %0d lane6 %0d expected 14 2", scan_cnt[4], scan_cnt[6]);
    end
  endtask

  task automatic test_clear();
    clr = 1'b1;
    rep_lane = 3'd1;
    rep_qty = 7'd7;
    rep_valid = 1'b1;
    sale_lane = 3'd4;
    sale_valid = 1'b1;
    tick();
    clr = 1'b0;
    sale_valid = 1'b0;
    checks++;
    if (rep_ack !== 1'b0 || sale_fail !== 1'b1 || empty_mask !== 8'hFF) begin
      errors++;
      $display("FAIL clear got ack %b fail %b empty %h expected 0 1 ff", rep_ack, sale_fail, empty_mask);
    end
    tick();
    checks++;
    if (rep_ack !== 1'b1 || empty_mask !== 8'hFD) begin
      errors++;
      $display("FAIL clear_then_rep got ack %b empty %h expected 1 fd", rep_ack, empty_mask);
    end
    rep_valid = 1'b0;
    tick();
  endtask

  task automatic test_scan_hold();
    int c = 1;
    int done_c = -1;
    int ack_c = -1;
    bit raised = 1'b0;
    logic [7:0] mask_at_ack = 8'h00;
    inq_req = 1'b1;
    tick();
    inq_req = 1'b0;
    while (c < 30) begin
      clr = 1'b0;
      if (inq_done) done_c = c;
      if (rep_ack) begin
        ack_c = c;
        mask_at_ack = empty_mask;
        break;
      end
      if (!raised && inq_valid && inq_lane == 3'd2) begin
        raised = 1'b1;
        rep_lane = 3'd0;
        rep_qty = 7'd9;
        rep_valid = 1'b1;
        clr = 1'b1;
      end
      tick();
      c++;
    end
    rep_valid = 1'b0;
    clr = 1'b0;
    checks++;
    if (done_c != 9 || ack_c != done_c + 2) begin
      errors++;
      $display("FAIL scan_hold got done at %0d ack at %0d expected 9 and 11", done_c, ack_c);
    end
    checks++;
    if (mask_at_ack !== 8'hFC) begin
      errors++;
      $display("FAIL scan_clr_dropped got empty %h expected fc", mask_at_ack);
    end
    tick();
  endtask

  task automatic test_en_drop();
    int nv = 0;
    bit done = 1'b0;
    inq_req = 1'b1;
    tick();
    inq_req = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (inq_valid) nv++;
      if (inq_valid && inq_lane == 3'd1) en = 1'b0;
      if (inq_done) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (nv != 8 || !done) begin
      errors++;
      $display("FAIL en_drop got %0d lanes done %b expected 8 1", nv, done);
    end
    tick();
    en = 1'b1;
  endtask

  task automatic test_rst_mid_scan();
    bit hit = 1'b0;
    inq_req = 1'b1;
    tick();
    inq_req = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (inq_valid && inq_lane == 3'd4) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (!hit || inq_busy !== 1'b0 || inq_valid !== 1'b0 || inq_done !== 1'b0 || empty_mask !== 8'hFF) begin
      errors++;
      $display("FAIL rst_scan got reached %b busy %b valid %b done %b empty %h expected 1 0 0 0 ff",
               hit, inq_busy, inq_valid, inq_done, empty_mask);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (inq_done !== 1'b0 || inq_busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_done cycle %0d got done %b busy %b expected 0 0", c, inq_done, inq_busy);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if (rep_valid && rep_ack) begin
        rep_valid = 1'b0;
      end else if (!rep_valid && $urandom_range(0, 3) == 0) begin
        rep_valid = 1'b1;
        rep_lane = 3'($urandom_range(0, 7));
        rep_qty = 7'($urandom_range(0, 60));
      end
      en = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 40) == 0);
      sale_valid = ($urandom_range(0, 1) == 1);
      sale_lane = 3'($urandom_range(0, 7));
      inq_req = ($urandom_range(0, 15) == 0);
      tick();
    end
    {rep_valid, clr, sale_valid, inq_req} = '0;
    en = 1'b1;
    for (int c = 0; c < 12; c++) tick();
  endtask

  initial begin
    test_reset();
    test_scan_empty();
    test_replenish();
    test_gating();
    test_sale();
    test_back_to_back();
    test_clear();
    test_scan_hold();
    test_en_drop();
    test_rst_mid_scan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1);
  end

endmodule

// File: doc/stock_keeper.md
Name: stock_keeper

Overview:
- Responder end of the admin command interface: owns the per-lane goods counts that the admin side only requests changes to.
- Executes clear-all, replenish and inquiry commands. Inquiry results are streamed back one lane per cycle.
- Also serves customer sale decrements from the purchase path.
- Sits between the admin block and the display/purchase logic of the vending machine.

Parameters:
- LANES, 8, number of goods lanes (lane index width = 3).
- CNT_W, 7, width of each lane count and of replenish quantity.
- MAX_CNT, 99, saturation ceiling per lane.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- en  in  1  admin unlocked (password accepted); gates clr/rep/inq
- clr  in  1  admin clear-all strobe
- rep_valid  in  1  replenish request, held until rep_ack
- rep_lane  in  3  lane to replenish
- rep_qty  in  CNT_W  quantity to add
- rep_ack  out  1  one-cycle pulse: replenish applied
- rep_sat  out  1  valid with rep_ack; result clamped to MAX_CNT
- inq_req  in  1  inquiry start strobe
- inq_busy  out  1  scan in progress
- inq_valid  out  1  inq_lane/inq_count valid this cycle
- inq_lane  out  3  lane being reported
- inq_count  out  CNT_W  count of inq_lane
- inq_done  out  1  one-cycle pulse after last lane
- sale_valid  in  1  customer purchase strobe
- sale_lane  in  3  lane purchased
- sale_ok  out  1  one-cycle pulse: decrement done
- sale_fail  out  1  one-cycle pulse: lane empty or collision
- empty_mask  out  LANES  bit i = 1 when lane i count is 0

Behaviour:
- Reset:
  - All counts = 0; empty_mask = all ones.
  - FSM = IDLE.
  - All pulse/valid outputs = 0; inq_lane = 0; inq_count = 0.
- Registered outputs; every response appears the cycle after the triggering input.
- FSM states:
  - IDLE -> SCAN on inq_req & en.
  - SCAN: lane index k steps 0..LANES-1, one per cycle; inq_valid = 1, inq_lane = k, inq_count = count[k].
  - SCAN -> DONE after k = LANES-1.
  - DONE: inq_done = 1 for one cycle, then -> IDLE.
- inq_req while busy: ignored.
- Admin gating:
  - en low: clr, rep_valid and inq_req are ignored, no ack.
  - en falling mid-scan: scan completes normally.
- Admin commands are accepted only in IDLE:
  - A rep_valid raised during SCAN/DONE waits; it is acked in the first IDLE cycle.
  - A clr asserted during SCAN/DONE is dropped.
- Priority within one IDLE cycle: clr > rep > sale.
  - clr: all counts = 0. A coincident rep_valid is not acked (requester holds it and is served next cycle). A coincident sale gets sale_fail.
  - rep: new = count + qty, computed CNT_W+1 wide. If new > MAX_CNT, count = MAX_CNT and rep_sat = 1.
  - rep with qty = 0: acked, count unchanged.
- Sales:
  - Accepted in any state, and not gated by en.
  - count > 0: decrement, sale_ok.
  - count = 0: sale_fail, count stays 0.
  - Same-cycle rep on the same lane: rep applied, sale_fail.
  - Same-cycle rep on a different lane: both applied.
- A sale during SCAN updates the count. inq_count reflects the count sampled when that lane is reported; no snapshot.
- empty_mask is derived from the registered counts, same cycle as the counts.
- rst mid-scan: immediate return to IDLE with all reset values; no inq_done.

Decomposition:
- Shared package holds:
  - LANE_W = 3, CNT_W = 7, MAX_CNT = 99
  - FSM state enum {IDLE, SCAN, DONE}
  - lane-index typedef (reused by the admin block and the display)
- One natural sub-module, stock_sat_add: combinational saturating add/decrement, returns new count and sat flag.

Test Plan:
- rst, then en = 1, inq_req -> inq_valid on 8 consecutive cycles, lanes 0..7, all inq_count = 0; inq_done next cycle; empty_mask = 8'hFF.
- en = 1, rep lane 3 qty 40, then again qty 70 -> first ack with count 40 and rep_sat = 0; second ack with count 99 and rep_sat = 1; empty_mask[3] = 0.
- en = 0, rep_valid lane 2 qty 5 held 4 cycles -> no rep_ack, count[2] stays 0. Raise en -> rep_ack next cycle, count[2] = 5.
- count[5] = 1; sale lane 5 twice -> sale_ok, then sale_fail; count[5] = 0; empty_mask[5] = 1.
- Same cycle, count[4] = 10: rep lane 4 qty 2 and sale lane 4 -> rep_ack, sale_fail, count = 12. Repeat with sale lane 6 at count 3 -> both applied, count[6] = 2.
- Start scan, assert rep_valid at lane index 2 -> rep_ack only after inq_done. Assert rst at lane index 4 -> next cycle inq_busy = 0, no inq_done, all counts 0.
